// File: rtl/eprisc_iobus_master_if.sv
// eprisc_iobus_master_if
//   Groups the CPU-side request/response handshake and the controller-side
//   bus pins of the epRISC I/O bus master into one bundle.
//   master modport : seen by eprisc_iobus_master (drives o*, reads i*)
//   slave  modport : seen by the CPU / controller side (drives i*, reads o*)
//   CPU side   : iReq, iWrite, iAddr[14:0], iData[15:0] -> oAck, oRdValid,
//                oRdData[15:0], oIdle, oInterrupt
//   Bus side   : oBusClock, oBusSelect[1:0], oBusMOSI[7:0], iBusMISO[7:0],
//                iBusInterrupt
interface eprisc_iobus_master_if;
    logic        iReq;
    logic        iWrite;
    logic [14:0] iAddr;
    logic [15:0] iData;
    logic        oAck;
    logic        oRdValid;
    logic [15:0] oRdData;
    logic        oIdle;
    logic        oInterrupt;
    logic        oBusClock;
    logic [1:0]  oBusSelect;
    logic [7:0]  oBusMOSI;
    logic [7:0]  iBusMISO;
    logic        iBusInterrupt;

    modport master (
        input  iReq, iWrite, iAddr, iData, iBusMISO, iBusInterrupt,
        output oAck, oRdValid, oRdData, oIdle, oInterrupt,
               oBusClock, oBusSelect, oBusMOSI
    );

    modport slave (
        output iReq, iWrite, iAddr, iData, iBusMISO, iBusInterrupt,
        input  oAck, oRdValid, oRdData, oIdle, oInterrupt,
               oBusClock, oBusSelect, oBusMOSI
    );
endinterface

// File: rtl/eprisc_iobus_master.sv
// eprisc_iobus_master
//   Host-side master for the epRISC I/O controller bus. Each CPU request is
//   packed into a 7-bus-cycle frame {wr, addr, data} sent LSB byte first;
//   read data for frame N comes back in BC0/BC1 of frame N+1.
// Ports
//   iClk  : system clock, everything on posedge
//   iRst  : synchronous active-high reset
//   bus   : eprisc_iobus_master_if.master (request/response + bus pins)
// Parameters
//   CLK_DIV          : iClk cycles per bus-clock half period (>= 2)
//   RESET_BUS_CYCLES : bus-clock rises the controller is held in reset
module eprisc_iobus_master #(
    parameter int CLK_DIV          = 4,
    parameter int RESET_BUS_CYCLES = 8
) (
    input  logic                  iClk,
    input  logic                  iRst,
    eprisc_iobus_master_if.master bus
);
    localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RC_W = $clog2(RESET_BUS_CYCLES + 1);
    localparam logic [PW-1:0]   PH_MAX  = PW'(CLK_DIV - 1);
    localparam logic [RC_W-1:0] HOLD_N  = RC_W'(RESET_BUS_CYCLES);
    localparam logic [31:0]     NOP_WORD = 32'h7FFF_0000;

    localparam logic [0:0] ST_HOLD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      r_state;
    logic [PW-1:0]   r_phase;
    logic            r_bclk;
    logic [RC_W-1:0] r_rstcnt;
    logic [2:0]      r_bc;
    logic [31:0]     r_word;
    logic [7:0]      r_mosi;
    logic            r_ack;
    logic            r_cur_req;   // this frame carries a CPU request
    logic            r_cur_rd;    // ...and it is a read
    logic            r_prev_rd;   // previous frame was a read, data still due
    logic [7:0]      r_rdlo;
    logic [15:0]     r_rddata;
    logic            r_rdvalid;
    logic [1:0]      r_irq_sync;

    logic        w_wrap;
    logic        w_rise;
    logic        w_hold_done;
    logic        w_frame_start;
    logic [31:0] w_word;
    logic [2:0]  w_bc_next;
    logic [7:0]  w_byte;

    always_comb begin
        w_wrap        = (r_phase == PH_MAX);
        w_rise        = w_wrap && !r_bclk;
        w_hold_done   = (r_rstcnt == HOLD_N);
        // The rise that releases the controller also opens the first frame.
        w_frame_start = w_rise && ((r_state == ST_RUN) ? (r_bc == 3'd6) : w_hold_done);
        w_word        = r_word;
        if (w_frame_start)
            w_word = bus.iReq ? {bus.iWrite, bus.iAddr, bus.iData} : NOP_WORD;
        w_bc_next     = w_frame_start ? 3'd0 : r_bc + 3'd1;
        case (w_bc_next)
            3'd0:    w_byte = w_word[7:0];
            3'd1:    w_byte = w_word[15:8];
            3'd2:    w_byte = w_word[23:16];
            3'd3:    w_byte = w_word[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= ST_HOLD;
            r_phase    <= '0;
            r_bclk     <= 1'b0;
            r_rstcnt   <= '0;
            r_bc       <= 3'd0;
            r_word     <= '0;
            r_mosi     <= 8'h00;
            r_ack      <= 1'b0;
            r_cur_req  <= 1'b0;
            r_cur_rd   <= 1'b0;
            r_prev_rd  <= 1'b0;
            r_rdlo     <= 8'h00;
            r_rddata   <= 16'h0000;
            r_rdvalid  <= 1'b0;
            r_irq_sync <= 2'b00;
        end else begin
            r_ack      <= 1'b0;
            r_rdvalid  <= 1'b0;
            r_irq_sync <= {r_irq_sync[0], bus.iBusInterrupt};
            r_phase    <= w_wrap ? '0 : r_phase + 1'b1;
            if (w_wrap)
                r_bclk <= ~r_bclk;

            if (w_rise) begin
                if (r_state == ST_HOLD) begin
                    if (w_hold_done)
                        r_state <= ST_RUN;
                    else
                        r_rstcnt <= r_rstcnt + 1'b1;
                end

                if (r_state == ST_RUN || w_frame_start) begin
                    r_bc   <= w_bc_next;
                    r_mosi <= w_byte;
                end

                if (w_frame_start) begin
                    r_word    <= w_word;
                    r_ack     <= bus.iReq;
                    r_cur_req <= bus.iReq;
                    r_cur_rd  <= bus.iReq && !bus.iWrite;
                    r_prev_rd <= r_cur_rd;
                end

                // MISO is captured at the rise that closes BC0 / BC1.
                if (r_state == ST_RUN && r_bc == 3'd0)
                    r_rdlo <= bus.iBusMISO;
                if (r_state == ST_RUN && r_bc == 3'd1 && r_prev_rd) begin
                    r_rddata  <= {bus.iBusMISO, r_rdlo};
                    r_rdvalid <= 1'b1;
                    r_prev_rd <= 1'b0;
                end
            end
        end
    end

    assign bus.oAck       = r_ack;
    assign bus.oRdValid   = r_rdvalid;
    assign bus.oRdData    = r_rddata;
    assign bus.oIdle      = !r_cur_req && !r_prev_rd;
    assign bus.oInterrupt = r_irq_sync[1];
    assign bus.oBusClock  = r_bclk;
    assign bus.oBusSelect = (r_state == ST_RUN) ? 2'h1 : 2'h0;
    assign bus.oBusMOSI   = r_mosi;
endmodule

// File: tb/tb_eprisc_iobus_master.sv
// tb_eprisc_iobus_master
//   Directed stimulus with a scoreboard: request tasks push the expected frame
//   word, ack and read data; a negedge monitor plays the controller (returns
//   MISO bytes from a small memory) and pops/compares on every DUT output.
module tb_eprisc_iobus_master;
    localparam int CLK_DIV          = 4;
    localparam int RESET_BUS_CYCLES = 8;
    localparam int BUS_PER          = 2 * CLK_DIV;
    localparam int FRAME_CYC        = 7 * BUS_PER;
    localparam logic [31:0] NOP     = 32'h7FFF_0000;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    always #5 iClk = ~iClk;

    eprisc_iobus_master_if bus ();

    eprisc_iobus_master #(.CLK_DIV(CLK_DIV), .RESET_BUS_CYCLES(RESET_BUS_CYCLES)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_word_q[$];
    logic        exp_kind_q[$];   // 1 = read
    logic [15:0] exp_rd_q[$];
    int          rd_ack_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / controller model ----------------
    int          cyc = 0;
    logic        prev_bclk = 1'b0;
    int          last_tog = 0;
    bit          tog_valid = 0;
    int          tog_checks = 0;
    bit          hold_track = 1;
    int          hold_rises = 0;
    bit          in_frame = 0;
    int          bc = 0;
    logic [31:0] fword = '0;
    logic [15:0] ret = '0;
    logic [15:0] mem [logic [14:0]];

    initial begin
        mem[15'h0040] = 16'h1234;
        mem[15'h0010] = 16'hA5C3;
    end

    always @(negedge iClk) begin
        cyc++;
        if (iRst) begin
            exp_word_q.delete();
            exp_kind_q.delete();
            exp_rd_q.delete();
            rd_ack_cyc_q.delete();
            hold_track = 1;
            hold_rises = 0;
            tog_valid  = 0;
            in_frame   = 0;
            ret        = '0;
            bus.iBusMISO = 8'h00;
            prev_bclk  = bus.oBusClock;
        end else begin
            if (bus.oBusClock !== prev_bclk) begin
                if (tog_valid && tog_checks < 6) begin
                    chk("bclk_half_period", cyc - last_tog, CLK_DIV);
                    tog_checks++;
                end
                tog_valid = 1;
                last_tog  = cyc;
            end
            if (bus.oBusClock === 1'b1 && prev_bclk === 1'b0) begin
                if (hold_track) begin
                    hold_rises++;
                    if (bus.oBusSelect == 2'h1) begin
                        chk("hold_rises", hold_rises, RESET_BUS_CYCLES + 1);
                        hold_track = 0;
                    end
                end
                if (bus.oBusSelect == 2'h1) begin
                    bc = in_frame ? ((bc == 6) ? 0 : bc + 1) : 0;
                    in_frame = 1;
                    case (bc)
                        0: begin fword[7:0] = bus.oBusMOSI;   bus.iBusMISO = ret[7:0];  end
                        1: begin fword[15:8] = bus.oBusMOSI;  bus.iBusMISO = ret[15:8]; end
                        2: fword[23:16] = bus.oBusMOSI;
                        3: begin
                            fword[31:24] = bus.oBusMOSI;
                            if (fword == NOP) begin
                                if (exp_word_q.size() == 0) chk("nop_frame", fword, NOP);
                            end else if (exp_word_q.size() == 0) begin
                                chk("unexpected_frame", fword, NOP);
                            end else begin
                                chk("frame_word", fword, exp_word_q.pop_front());
                            end
                            ret = 16'h0000;
                            if (!fword[31] && mem.exists(fword[30:16])) ret = mem[fword[30:16]];
                            if (fword[31]) mem[fword[30:16]] = fword[15:0];
                        end
                        default: chk("pad_byte", bus.oBusMOSI, 8'h00);
                    endcase
                end
            end
            if (bus.oAck === 1'b1) begin
                if (exp_kind_q.size() == 0) chk("unexpected_ack", 1, 0);
                else if (exp_kind_q.pop_front()) rd_ack_cyc_q.push_back(cyc);
            end
            if (bus.oRdValid === 1'b1) begin
                chk("ack_rdvalid_overlap", bus.oAck, 0);
                if (exp_rd_q.size() == 0) begin
                    chk("unexpected_rdvalid", bus.oRdData, 16'h0000);
                    errors += (bus.oRdData === 16'h0000) ? 1 : 0;
                end else begin
                    chk("rd_data", bus.oRdData, exp_rd_q.pop_front());
                    if (rd_ack_cyc_q.size() != 0)
                        chk("rd_latency", cyc - rd_ack_cyc_q.pop_front(), 18 * CLK_DIV);
                end
            end
            prev_bclk = bus.oBusClock;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input logic wr, input logic [14:0] a, input logic [15:0] d,
                          input logic [15:0] rd_exp, output int n);
        bit got;
        exp_word_q.push_back({wr, a, d});
        exp_kind_q.push_back(!wr);
        if (!wr) exp_rd_q.push_back(rd_exp);
        bus.iReq = 1'b1; bus.iWrite = wr; bus.iAddr = a; bus.iData = d;
        n = 0; got = 0;
        while (!got && n < 4 * FRAME_CYC) begin
            @(negedge iClk);
            n++;
            if (bus.oAck === 1'b1) got = 1;
        end
        bus.iReq = 1'b0;
        chk("ack_seen", got, 1);
    endtask

    task automatic wait_select();
        int n = 0;
        while (bus.oBusSelect !== 2'h1 && n < 40 * BUS_PER) begin
            @(negedge iClk);
            n++;
        end
        chk("select_up", bus.oBusSelect, 2'h1);
    endtask

    task automatic wait_rd_done();
        int n = 0;
        while (exp_rd_q.size() != 0 && n < 4 * FRAME_CYC) begin
            @(negedge iClk);
            n++;
        end
        chk("rd_done", exp_rd_q.size(), 0);
        repeat (BUS_PER) @(negedge iClk);
    endtask

    initial begin
        int n;
        bus.iReq = 1'b0; bus.iWrite = 1'b0; bus.iAddr = '0; bus.iData = '0;
        bus.iBusMISO = 8'h00; bus.iBusInterrupt = 1'b0;
        iRst = 1'b1;
        repeat (3) @(negedge iClk);
        chk("rst_ack", bus.oAck, 0);
        chk("rst_rdvalid", bus.oRdValid, 0);
        chk("rst_rddata", bus.oRdData, 0);
        chk("rst_idle", bus.oIdle, 1);
        chk("rst_irq", bus.oInterrupt, 0);
        chk("rst_bclk", bus.oBusClock, 0);
        chk("rst_select", bus.oBusSelect, 0);
        chk("rst_mosi", bus.oBusMOSI, 0);
        iRst = 1'b0;

        // idle frames: NOPs only
        wait_select();
        repeat (3 * FRAME_CYC) @(negedge iClk);
        chk("idle_quiet", bus.oIdle, 1);

        // write 0x0012 <- BEEF
        do_req(1'b1, 15'h0012, 16'hBEEF, 16'h0000, n);
        repeat (2 * FRAME_CYC) @(negedge iClk);
        chk("idle_after_wr", bus.oIdle, 1);

        // single read
        do_req(1'b0, 15'h0040, 16'h0000, 16'h1234, n);
        chk("idle_busy", bus.oIdle, 0);
        wait_rd_done();

        // back-to-back reads: acks one frame apart
        do_req(1'b0, 15'h0040, 16'h0000, 16'h1234, n);
        do_req(1'b0, 15'h0010, 16'h0000, 16'hA5C3, n);
        chk("b2b_ack_gap", n, FRAME_CYC);
        wait_rd_done();

        // read back the written location
        do_req(1'b0, 15'h0012, 16'h0000, 16'hBEEF, n);
        wait_rd_done();
        chk("idle_end_reads", bus.oIdle, 1);

        // reset at BC3 of a read frame: no data must follow
        do_req(1'b0, 15'h0040, 16'h0000, 16'h1234, n);
        repeat (3 * BUS_PER + 2) @(negedge iClk);
        iRst = 1'b1;
        repeat (3) @(negedge iClk);
        chk("midrst_select", bus.oBusSelect, 0);
        chk("midrst_idle", bus.oIdle, 1);
        iRst = 1'b0;
        wait_select();
        repeat (2 * FRAME_CYC) @(negedge iClk);

        // interrupt synchroniser
        bus.iBusInterrupt = 1'b1;
        @(negedge iClk); chk("irq_rise_1clk", bus.oInterrupt, 0);
        @(negedge iClk); chk("irq_rise_2clk", bus.oInterrupt, 1);
        bus.iBusInterrupt = 1'b0;
        @(negedge iClk); chk("irq_fall_1clk", bus.oInterrupt, 1);
        @(negedge iClk); chk("irq_fall_2clk", bus.oInterrupt, 0);

        chk("left_words", exp_word_q.size(), 0);
        chk("left_acks", exp_kind_q.size(), 0);
        chk("left_reads", exp_rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=%0d exp=done", cyc);
        $fatal(1, "watchdog");
    end
endmodule
